cellram_responder: RTL and testbench

Synthesizable responder for the on-board Cellular RAM asynchronous-mode bus. It answers the RamCE/MemOE/MemWE strobe cycles issued by the RAM controller, backed by an internal block-RAM word array. It is used for on-FPGA loopback of the controller and the ANN weight-load paths when the external chip is bypassed. The block samples the asynchronous strobes with the system clock, commits writes on the WE or CE rising edge, and drives read data after a programmable latency.

---
 rtl/cellram_responder.sv | 172 +++++++++++++++++
 tb/tb_cellram_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cellram_responder.sv
// cellram_responder: block-RAM backed responder for the Cellular RAM async bus (optional checker: CELLRAM_RESP_CHECK_EN)
module cellram_responder #(
   parameter int ADDR_W   = 23,
   parameter int DEPTH_W  = 10,
   parameter int READ_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W:1]   mem_adr,
   input  logic [15:0]       mem_db_in,
   output logic [15:0]       mem_db_out,
   output logic              mem_db_oe,
   input  logic              ram_ce_n,
   input  logic              mem_oe_n,
   input  logic              mem_we_n,
   input  logic              ram_lb_n,
   input  logic              ram_ub_n,
   input  logic              ram_adv_n,
   input  logic              ram_clk,
   output logic              busy,
   output logic              err
);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE, WR_COMMIT} state_t;
   // the IDLE decision edge is the first latency cycle, so RD_WAIT holds READ_LAT-1 cycles
   localparam logic [3:0] CNT_LOAD = READ_LAT > 1 ? 4'(READ_LAT - 2) : 4'd0;
   logic [4:0]        str_q1, str_q2;
   logic [ADDR_W:1]   adr_q1, adr_q2;
   logic [15:0]       dat_q1, dat_q2;
   logic              ce, oe, we, lb, ub;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W:1]   rd_adr_q, rd_adr_d;
   logic [15:0]       db_out_q, db_out_d;
   logic              oe_q, oe_d;
   logic [DEPTH_W-1:0] wr_idx_q, wr_idx_d;
   logic [15:0]       wr_dat_q, wr_dat_d;
   logic              wr_lb_q, wr_lb_d, wr_ub_q, wr_ub_d;
   logic [15:0]       mem_q [2**DEPTH_W];
   // two-stage synchronizer shared by strobes, lanes, address and data so they stay aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         str_q1 <= '1;
         str_q2 <= '1;
         adr_q1 <= '0;
         adr_q2 <= '0;
         dat_q1 <= '0;
         dat_q2 <= '0;
      end else begin
         str_q1 <= {ram_ce_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n};
         str_q2 <= str_q1;
         adr_q1 <= mem_adr;
         adr_q2 <= adr_q1;
         dat_q1 <= mem_db_in;
         dat_q2 <= dat_q1;
      end
   end
   assign {ce, oe, we, lb, ub} = ~str_q2;
   // FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_adr_q <= '0;
         db_out_q <= '0;
         oe_q     <= 1'b0;
         wr_idx_q <= '0;
         wr_dat_q <= '0;
         wr_lb_q  <= 1'b0;
         wr_ub_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_adr_q <= rd_adr_d;
         db_out_q <= db_out_d;
         oe_q     <= oe_d;
         wr_idx_q <= wr_idx_d;
         wr_dat_q <= wr_dat_d;
         wr_lb_q  <= wr_lb_d;
         wr_ub_q  <= wr_ub_d;
      end
   end
   // byte-lane masked commit; a reset on the commit edge drops the write
   always_ff @(posedge clk) begin
      if (!rst && state_q == WR_COMMIT) begin
         if (wr_lb_q) mem_q[wr_idx_q][7:0] <= wr_dat_q[7:0];
         if (wr_ub_q) mem_q[wr_idx_q][15:8] <= wr_dat_q[15:8];
      end
   end
   // next-state and output decode; read strobes only count while no write is in progress
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_adr_d = rd_adr_q;
      db_out_d = db_out_q;
      oe_d     = oe_q;
      wr_idx_d = wr_idx_q;
      wr_dat_d = wr_dat_q;
      wr_lb_d  = wr_lb_q;
      wr_ub_d  = wr_ub_q;
      case (state_q)
         IDLE: begin
            oe_d = 1'b0;
            if (ce && we) state_d = WR_ACTIVE;
            else if (ce && oe) begin
               rd_adr_d = adr_q2;
               if (READ_LAT == 1) begin
                  db_out_d = mem_q[adr_q2[DEPTH_W:1]];
                  oe_d     = 1'b1;
                  state_d  = RD_DRIVE;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (!(ce && oe)) begin
               oe_d    = 1'b0;
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               db_out_d = mem_q[rd_adr_q[DEPTH_W:1]];
               oe_d     = 1'b1;
               state_d  = RD_DRIVE;
            end else cnt_d = cnt_q - 4'd1;
         end
         RD_DRIVE: begin
            if (!(ce && oe)) begin
               oe_d    = 1'b0;
               state_d = IDLE;
            end else if (adr_q2 != rd_adr_q) begin
               rd_adr_d = adr_q2;
               if (READ_LAT == 1) db_out_d = mem_q[adr_q2[DEPTH_W:1]];
               else begin
                  cnt_d   = CNT_LOAD;
                  state_d = RD_WAIT;
               end
            end
         end
         WR_ACTIVE: begin
            wr_idx_d = adr_q2[DEPTH_W:1];
            wr_dat_d = dat_q2;
            wr_lb_d  = lb;
            wr_ub_d  = ub;
            if (!(ce && we)) state_d = WR_COMMIT;
         end
         WR_COMMIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign mem_db_out = db_out_q;
   assign mem_db_oe  = oe_q;
   assign busy       = state_q != IDLE;
`ifdef CELLRAM_RESP_CHECK_EN
   logic [1:0] mode_q1, mode_q2;
   logic       err_q;
   // sticky protocol checker on the synchronized strobes and async-mode pins
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q1 <= '0;
         mode_q2 <= '0;
         err_q   <= 1'b0;
      end else begin
         mode_q1 <= {ram_adv_n, ram_clk};
         mode_q2 <= mode_q1;
         if ((ce && oe && we) || (ce && |mode_q2) || (oe && state_q == WR_ACTIVE)) err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0 & ram_adv_n & ram_clk;
`endif
endmodule

// File: tb/tb_cellram_responder.sv
// tb_cellram_responder: scoreboard bench for cellram_responder (honours CELLRAM_RESP_CHECK_EN)
module tb_cellram_responder;
   localparam int READ_LAT = 3;
`ifdef CELLRAM_RESP_CHECK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:1] mem_adr = '0;
   logic [15:0] mem_db_in = '0;
   logic [15:0] mem_db_out;
   logic        mem_db_oe, busy, err;
   logic        ram_ce_n = 1'b1, mem_oe_n = 1'b1, mem_we_n = 1'b1;
   logic        ram_lb_n = 1'b1, ram_ub_n = 1'b1, ram_adv_n = 1'b0, ram_clk = 1'b0;
   logic [15:0] model [1024];
   logic [15:0] exp_q [$];
   int          checks = 0, errors = 0;
   cellram_responder #(.ADDR_W(23), .DEPTH_W(10), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .rst(rst), .mem_adr(mem_adr), .mem_db_in(mem_db_in),
      .mem_db_out(mem_db_out), .mem_db_oe(mem_db_oe), .ram_ce_n(ram_ce_n),
      .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .ram_lb_n(ram_lb_n),
      .ram_ub_n(ram_ub_n), .ram_adv_n(ram_adv_n), .ram_clk(ram_clk),
      .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic bus_write(input logic [22:0] a, input logic [15:0] d, input logic lb, input logic ub);
      @(negedge clk);
      mem_adr = a; mem_db_in = d; ram_lb_n = !lb; ram_ub_n = !ub; ram_ce_n = 1'b0; mem_we_n = 1'b0;
      repeat (4) @(negedge clk);
      check("wr_busy", busy, 1);
      check("wr_oe", mem_db_oe, 0);
      ram_ce_n = 1'b1; mem_we_n = 1'b1;
      repeat (6) @(negedge clk);
      ram_lb_n = 1'b1; ram_ub_n = 1'b1;
      if (lb) model[a[9:0]][7:0] = d[7:0];
      if (ub) model[a[9:0]][15:8] = d[15:8];
   endtask
   task automatic bus_read(input string tag, input logic [22:0] a, input logic rechg, input logic [22:0] b);
      int n;
      logic [15:0] e;
      exp_q.push_back(model[a[9:0]]);
      @(negedge clk);
      mem_adr = a; ram_ce_n = 1'b0; mem_oe_n = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!mem_db_oe && n < 40);
      e = exp_q.pop_front();
      check({tag, "_lat"}, n, 2 + READ_LAT);
      check({tag, "_data"}, mem_db_out, e);
      if (rechg) begin
         exp_q.push_back(model[b[9:0]]);
         @(negedge clk);
         mem_adr = b;
         for (int k = 0; k < 2 + READ_LAT; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_oe"}, mem_db_oe, 1);
         end
         e = exp_q.pop_front();
         check({tag, "_reread"}, mem_db_out, e);
      end
      @(negedge clk);
      ram_ce_n = 1'b1; mem_oe_n = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (mem_db_oe && n < 40);
      check({tag, "_fall"}, n, 3);
      check({tag, "_idle"}, busy, 0);
      repeat (3) @(negedge clk);
   endtask
   task automatic check_reset(input string tag);
      check({tag, "_out"}, mem_db_out, 0);
      check({tag, "_oe"}, mem_db_oe, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
   endtask
   initial begin
      int seen;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      check_reset("rst");
      bus_write(23'h000005, 16'hBEEF, 1, 1);
      bus_read("beef", 23'h000005, 0, 0);
      bus_write(23'h000009, 16'h1234, 1, 1);
      bus_write(23'h000009, 16'hAB00, 0, 1);
      bus_read("ubonly", 23'h000009, 0, 0);
      bus_write(23'h000400, 16'h5555, 1, 1);
      bus_read("alias", 23'h000000, 0, 0);
      bus_read("rechg", 23'h000005, 1, 23'h000009);
      @(negedge clk);
      mem_adr = 23'h000005; ram_ce_n = 1'b0; mem_oe_n = 1'b0;
      @(negedge clk);
      ram_ce_n = 1'b1; mem_oe_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (k == 2) check("abort_idle", busy, 0);
         if (mem_db_oe) seen = 1;
      end
      check("abort_no_oe", seen, 0);
      bus_write(23'h000003, 16'h0001, 1, 1);
      @(negedge clk);
      mem_adr = 23'h000003; mem_db_in = 16'hFFFF; ram_lb_n = 1'b0; ram_ub_n = 1'b0; ram_ce_n = 1'b0; mem_we_n = 1'b0;
      repeat (4) @(negedge clk);
      check("rstwr_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      ram_ce_n = 1'b1; mem_we_n = 1'b1; ram_lb_n = 1'b1; ram_ub_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset("rstwr");
      repeat (6) @(negedge clk);
      check_reset("rstwr_post");
      bus_read("rstwr", 23'h000003, 0, 0);
      @(negedge clk);
      mem_adr = 23'h000003; ram_ce_n = 1'b0; mem_oe_n = 1'b0; mem_we_n = 1'b0;
      repeat (4) @(negedge clk);
      ram_ce_n = 1'b1; mem_oe_n = 1'b1; mem_we_n = 1'b1;
      repeat (8) @(negedge clk);
      check("err_set", err, {31'd0, CHK_EN});
      repeat (10) @(negedge clk);
      check("err_hold", err, {31'd0, CHK_EN});
      check("err_oe", mem_db_oe, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset("err_clr");
      bus_read("final", 23'h000003, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
